// File: rtl/ifm_deflatter_pkg.sv
// Shared widths, request-FSM encoding and lane-slice helper for the IFM deflatter.
package ifm_deflatter_pkg;

  localparam int unsigned WORD_W         = 512;
  localparam int unsigned LANE_W         = 32;
  localparam int unsigned LANES_PER_WORD = WORD_W / LANE_W;
  localparam int unsigned LANE_IDX_W     = $clog2(LANES_PER_WORD);
  localparam int unsigned WORD_IDX_W     = $clog2(WORD_W);
  localparam int unsigned WORD_BYTE      = 64;
  localparam int unsigned BURST_WORDS    = 2;
  localparam int unsigned FIFO_ADDR_BITS = 4;
  localparam int unsigned FIFO_DEPTH     = 1 << FIFO_ADDR_BITS;
  localparam int unsigned CNT_W          = FIFO_ADDR_BITS + 1;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2
  } rd_state_e;

  // Bit position of a lane inside a stream word.
  function automatic logic [WORD_IDX_W-1:0] lane_lsb(input logic [LANE_IDX_W-1:0] lane);
    return WORD_IDX_W'(32'(lane) * LANE_W);
  endfunction

endpackage

// File: rtl/ifm_deflatter_fifo.sv
// Word FIFO between the read stream and the lane unpacker; registered read port.
module rd_word_fifo
  import ifm_deflatter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [WORD_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] rd_data_o,
  output logic [CNT_W-1:0]  data_cnt_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [WORD_W-1:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr_q;
  logic [FIFO_ADDR_BITS-1:0] rd_ptr_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [WORD_W-1:0]         rd_data_q;
  logic                      push_ok;
  logic                      pop_ok;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;
  assign rd_data_o  = rd_data_q;
  assign data_cnt_o = cnt_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Read data only changes on a pop, so it doubles as the unpacker's held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ifm_deflatter.sv
// Reads 512-bit words via burst requests, buffers them, and feeds them to the
// conv engine one 32-bit lane per cycle.
module ifm_deflatter
  import ifm_deflatter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              op_start,
  input  logic [31:0]       num_words,
  input  logic [63:0]       rmst_offset,
  output logic              rmst_req,
  output logic [63:0]       rmst_addr,
  output logic [63:0]       rmst_xfer_size,
  input  logic              rmst_done,
  input  logic [WORD_W-1:0] tdata,
  input  logic              tvalid,
  output logic              tready,
  output logic [LANE_W-1:0] ifm_data,
  output logic              ifm_v,
  output logic              busy,
  output logic              end_read
);

  rd_state_e             state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  end_read_q, end_read_d;
  logic                  rmst_req_q, rmst_req_d;
  logic [63:0]           rmst_addr_q, rmst_addr_d;
  logic [63:0]           offset_q, offset_d;
  logic [31:0]           num_words_q, num_words_d;
  logic [31:0]           words_req_q, words_req_d;
  logic [31:0]           words_out_q, words_out_d;
  logic [LANE_IDX_W-1:0] lane_cnt_q, lane_cnt_d;
  logic                  hold_v_q, hold_v_d;
  logic                  last_q, last_d;
  logic                  ifm_v_q, ifm_v_d;
  logic [LANE_W-1:0]     ifm_data_q, ifm_data_d;

  logic [WORD_W-1:0]     fifo_rd_data;
  logic [CNT_W-1:0]      fifo_cnt;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CNT_W-1:0]      fifo_free_c;
  logic                  start_c;
  logic                  push_c;
  logic                  emit_c;
  logic                  lane_end_c;
  logic                  pop_c;

  assign start_c     = op_start & ~busy_q;
  assign tready      = busy_q & ~fifo_full;
  assign push_c      = tvalid & tready;
  assign emit_c      = busy_q & hold_v_q & ~stall;
  assign lane_end_c  = emit_c & (lane_cnt_q == LANE_IDX_W'(LANES_PER_WORD - 1));
  assign pop_c       = busy_q & ~fifo_empty & (~hold_v_q | lane_end_c);
  assign fifo_free_c = CNT_W'(FIFO_DEPTH) - fifo_cnt;

  rd_word_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_c),
    .push_data_i (tdata),
    .pop_i       (pop_c),
    .rd_data_o   (fifo_rd_data),
    .data_cnt_o  (fifo_cnt),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    end_read_d  = 1'b0;
    rmst_addr_d = rmst_addr_q;
    offset_d    = offset_q;
    num_words_d = num_words_q;
    words_req_d = words_req_q;
    words_out_d = words_out_q;
    lane_cnt_d  = lane_cnt_q;
    hold_v_d    = hold_v_q;
    last_d      = lane_end_c & (words_out_q == num_words_q - 32'd1);
    ifm_v_d     = emit_c;
    ifm_data_d  = emit_c ? fifo_rd_data[lane_lsb(lane_cnt_q) +: LANE_W] : ifm_data_q;

    // One outstanding burst, launched only when the FIFO can absorb it.
    case (state_q)
      R_IDLE: begin
        if (busy_q && !last_q && (words_req_q < num_words_q) &&
            (fifo_free_c >= CNT_W'(BURST_WORDS))) begin
          state_d     = R_REQ;
          rmst_addr_d = offset_q + 64'(words_req_q) * 64'(WORD_BYTE);
        end
      end
      R_REQ:  state_d = R_WAIT;
      R_WAIT: begin
        if (rmst_done) begin
          words_req_d = words_req_q + 32'(BURST_WORDS);
          state_d     = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase
    rmst_req_d = (state_d == R_REQ);

    if (emit_c) begin
      lane_cnt_d = lane_cnt_q + 1'b1;
    end
    if (lane_end_c) begin
      words_out_d = words_out_q + 32'd1;
    end
    if (pop_c) begin
      hold_v_d = 1'b1;
    end else if (lane_end_c) begin
      hold_v_d = 1'b0;
    end

    if (start_c) begin
      offset_d    = rmst_offset;
      num_words_d = num_words;
      if (num_words == 32'd0) begin
        end_read_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end

    // Final lane has just appeared on ifm_data: close out the operation.
    if (last_q) begin
      busy_d      = 1'b0;
      end_read_d  = 1'b1;
      state_d     = R_IDLE;
      rmst_req_d  = 1'b0;
      words_req_d = '0;
      words_out_d = '0;
      lane_cnt_d  = '0;
      hold_v_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= R_IDLE;
      busy_q      <= 1'b0;
      end_read_q  <= 1'b0;
      rmst_req_q  <= 1'b0;
      rmst_addr_q <= '0;
      offset_q    <= '0;
      num_words_q <= '0;
      words_req_q <= '0;
      words_out_q <= '0;
      lane_cnt_q  <= '0;
      hold_v_q    <= 1'b0;
      last_q      <= 1'b0;
      ifm_v_q     <= 1'b0;
      ifm_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      end_read_q  <= end_read_d;
      rmst_req_q  <= rmst_req_d;
      rmst_addr_q <= rmst_addr_d;
      offset_q    <= offset_d;
      num_words_q <= num_words_d;
      words_req_q <= words_req_d;
      words_out_q <= words_out_d;
      lane_cnt_q  <= lane_cnt_d;
      hold_v_q    <= hold_v_d;
      last_q      <= last_d;
      ifm_v_q     <= ifm_v_d;
      ifm_data_q  <= ifm_data_d;
    end
  end

  assign rmst_req       = rmst_req_q;
  assign rmst_addr      = rmst_addr_q;
  assign rmst_xfer_size = 64'(WORD_BYTE * BURST_WORDS);
  assign ifm_data       = ifm_data_q;
  assign ifm_v          = ifm_v_q;
  assign busy           = busy_q;
  assign end_read       = end_read_q;

endmodule

// File: tb/tb_ifm_deflatter.sv
// Directed bench for ifm_deflatter with a behavioural read master and lane monitor.
module tb_ifm_deflatter;
  import ifm_deflatter_pkg::*;

  logic         clk = 1'b0;
  logic         rst, stall, op_start, rmst_done, tvalid;
  logic [31:0]  num_words;
  logic [63:0]  rmst_offset;
  logic [511:0] tdata;
  logic         rmst_req, tready, ifm_v, busy, end_read;
  logic [63:0]  rmst_addr, rmst_xfer_size;
  logic [31:0]  ifm_data;

  int           vectors = 0;
  int           errors  = 0;
  logic [63:0]  cur_offset = '0;
  logic [31:0]  lanes[$];
  logic [63:0]  reqs[$];
  int           cyc = 0, beats = 0, overlap = 0;
  int           first_beat_cyc = -1, first_v_cyc = -1, last_v_cyc = -1, end_cyc = -1;
  bit           outstanding = 0, busy_seen = 0;

  always #5 clk = ~clk;

  ifm_deflatter dut (
    .clk(clk), .rst(rst), .stall(stall), .op_start(op_start),
    .num_words(num_words), .rmst_offset(rmst_offset),
    .rmst_req(rmst_req), .rmst_addr(rmst_addr), .rmst_xfer_size(rmst_xfer_size),
    .rmst_done(rmst_done), .tdata(tdata), .tvalid(tvalid), .tready(tready),
    .ifm_data(ifm_data), .ifm_v(ifm_v), .busy(busy), .end_read(end_read)
  );

  function automatic logic [511:0] mk(input int k);
    logic [511:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = 32'(k * 16 + i);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_lanes(input string tag, input int n);
    chk({tag, "_nlanes"}, 64'(lanes.size()), 64'(n));
    for (int i = 0; i < lanes.size() && i < n; i++)
      chk($sformatf("%s_lane%0d", tag, i), 64'(lanes[i]), 64'(i));
  endtask

  task automatic clear_log();
    lanes.delete(); reqs.delete();
    beats = 0; overlap = 0; busy_seen = 0;
    first_beat_cyc = -1; first_v_cyc = -1; last_v_cyc = -1; end_cyc = -1;
  endtask

  task automatic start(input logic [63:0] off, input logic [31:0] n);
    cur_offset = off; rmst_offset = off; num_words = n; op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
  endtask

  task automatic wait_end(input int max, input string tag);
    int n;
    n = 0;
    while (!end_read && n < max) begin @(negedge clk); n++; end
    chk(tag, 64'(end_read), 64'd1);
  endtask

  // Read master: answers each request with BURST_WORDS beats, then rmst_done.
  initial begin
    tvalid = 1'b0; tdata = '0; rmst_done = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (rmst_req && !rst) begin
        int k0;
        bit ab;
        k0 = int'((rmst_addr - cur_offset) >> 6);
        ab = 0;
        for (int b = 0; b < BURST_WORDS && !ab; b++) begin
          bit acc;
          acc = 0;
          tdata = mk(k0 + b); tvalid = 1'b1;
          while (!acc && !ab) begin
            if (!busy || rst) ab = 1; else acc = tready;
            @(negedge clk); #1;
          end
        end
        tvalid = 1'b0;
        if (!ab) begin
          rmst_done = 1'b1;
          @(negedge clk); #1;
          rmst_done = 1'b0;
        end
      end
    end
  end

  // Monitor: logs lanes, requests, accepted beats and event cycles.
  initial forever begin
    @(negedge clk); #2;
    cyc++;
    if (ifm_v) begin
      lanes.push_back(ifm_data);
      if (first_v_cyc < 0) first_v_cyc = cyc;
      last_v_cyc = cyc;
    end
    if (tvalid && tready) begin
      beats++;
      if (first_beat_cyc < 0) first_beat_cyc = cyc;
    end
    if (rmst_req) begin
      if (outstanding) overlap++;
      outstanding = 1;
      reqs.push_back(rmst_addr);
    end
    if (rmst_done) outstanding = 0;
    if (end_read) end_cyc = cyc;
    if (busy) busy_seen = 1;
  end

  initial begin
    int n;
    rst = 1'b1; stall = 1'b0; op_start = 1'b0; num_words = '0; rmst_offset = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", 64'(rmst_req), 64'd0);
    chk("rst_addr", rmst_addr, 64'd0);
    chk("rst_tready", 64'(tready), 64'd0);
    chk("rst_ifm_v", 64'(ifm_v), 64'd0);
    chk("rst_ifm_data", 64'(ifm_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_end_read", 64'(end_read), 64'd0);
    chk("xfer_size", rmst_xfer_size, 64'd128);
    rst = 1'b0;
    @(negedge clk);

    // Basic two-word read
    clear_log();
    start(64'h1000, 32'd2);
    chk("basic_busy", 64'(busy), 64'd1);
    wait_end(400, "basic_end");
    chk("basic_busy_drop", 64'(busy), 64'd0);
    @(negedge clk);
    chk("basic_end_pulse", 64'(end_read), 64'd0);
    chk("basic_nreq", 64'(reqs.size()), 64'd1);
    if (reqs.size() > 0) chk("basic_addr", reqs[0], 64'h1000);
    chk("basic_end_lat", 64'(end_cyc - last_v_cyc), 64'd1);
    chk("basic_first_lat", 64'(first_v_cyc - first_beat_cyc), 64'd3);
    check_lanes("basic", 32);

    // Multi-burst read from an unaligned-to-burst offset
    clear_log();
    start(64'h2040, 32'd8);
    wait_end(1000, "multi_end");
    @(negedge clk);
    chk("multi_nreq", 64'(reqs.size()), 64'd4);
    for (int i = 0; i < reqs.size() && i < 4; i++)
      chk($sformatf("multi_addr%0d", i), reqs[i], 64'h2040 + 64'(i) * 64'h80);
    chk("multi_overlap", 64'(overlap), 64'd0);
    check_lanes("multi", 128);

    // Stall for five cycles with lane 7 of word 0 current
    clear_log();
    start(64'h0, 32'd2);
    n = 0;
    while (!(ifm_v && ifm_data == 32'd6) && n < 200) begin @(negedge clk); n++; end
    chk("stall_reach_lane6", 64'(ifm_v && ifm_data == 32'd6), 64'd1);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_v%0d", i), 64'(ifm_v), 64'd0);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("stall_resume_v", 64'(ifm_v), 64'd1);
    chk("stall_resume_data", 64'(ifm_data), 64'd7);
    wait_end(400, "stall_end");
    @(negedge clk);
    check_lanes("stall", 32);

    // Backpressure: sink stalled from the start, requests must stop at the FIFO limit
    clear_log();
    stall = 1'b1;
    start(64'h4000, 32'd32);
    repeat (80) @(negedge clk);
    chk("bp_nreq_held", 64'(reqs.size()), 64'd8);
    chk("bp_beats_held", 64'(beats), 64'd16);
    chk("bp_no_lanes", 64'(lanes.size()), 64'd0);
    chk("bp_busy", 64'(busy), 64'd1);
    stall = 1'b0;
    wait_end(3000, "bp_end");
    @(negedge clk);
    chk("bp_nreq", 64'(reqs.size()), 64'd16);
    for (int i = 0; i < reqs.size() && i < 16; i++)
      chk($sformatf("bp_addr%0d", i), reqs[i], 64'h4000 + 64'(i) * 64'h80);
    chk("bp_overlap", 64'(overlap), 64'd0);
    check_lanes("bp", 512);

    // Zero-length operation
    clear_log();
    start(64'h6000, 32'd0);
    chk("zero_end_read", 64'(end_read), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("zero_end_pulse", 64'(end_read), 64'd0);
    repeat (10) @(negedge clk);
    chk("zero_nreq", 64'(reqs.size()), 64'd0);
    chk("zero_busy_seen", 64'(busy_seen), 64'd0);

    // Reset in the middle of an operation, then a fresh read
    clear_log();
    start(64'h5000, 32'd4);
    n = 0;
    while (lanes.size() < 10 && n < 400) begin @(negedge clk); n++; end
    chk("mid_reach", 64'(lanes.size() >= 10), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_req", 64'(rmst_req), 64'd0);
    chk("mid_addr", rmst_addr, 64'd0);
    chk("mid_tready", 64'(tready), 64'd0);
    chk("mid_ifm_v", 64'(ifm_v), 64'd0);
    chk("mid_ifm_data", 64'(ifm_data), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_end_read", 64'(end_read), 64'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    clear_log();
    start(64'h3000, 32'd2);
    wait_end(400, "restart_end");
    @(negedge clk);
    chk("restart_nreq", 64'(reqs.size()), 64'd1);
    if (reqs.size() > 0) chk("restart_addr", reqs[0], 64'h3000);
    check_lanes("restart", 32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
